// File: rtl/csla_sub_64bit_pipe.sv
// rtl/csla_sub_64bit_pipe.sv - two-stage 64-bit carry-select subtractor with valid/ready flow control; CSLA_SUB_OVF_EN adds signed overflow output ovf
module csla_sub_64bit_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
`ifdef CSLA_SUB_OVF_EN
  output logic        ovf,
`endif
  output logic        bout
);

  // 32-bit carry-select adder: segments of 4,5,6,7,10 bits. The first segment
  // ripples from cin; each later segment ripples twice (carry 0 and carry 1)
  // and the carry selected out of the previous segment picks the result.
  function automatic logic [32:0] csel_add32(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic        cin);
    logic [31:0] s0, s1, s;
    logic        c0, c1, csel;
    int          lo, hi;
    s0   = '0;
    s1   = '0;
    s    = '0;
    csel = cin;
    lo   = 0;
    hi   = 0;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       begin lo = 0;  hi = 3;  end
        1:       begin lo = 4;  hi = 8;  end
        2:       begin lo = 9;  hi = 14; end
        3:       begin lo = 15; hi = 21; end
        default: begin lo = 22; hi = 31; end
      endcase
      c0 = (k == 0) ? cin : 1'b0;
      c1 = (k == 0) ? cin : 1'b1;
      for (int i = 0; i < 32; i++) begin
        if (i >= lo && i <= hi) begin
          s0[i] = x[i] ^ y[i] ^ c0;
          c0    = (x[i] & y[i]) | (c0 & (x[i] ^ y[i]));
          s1[i] = x[i] ^ y[i] ^ c1;
          c1    = (x[i] & y[i]) | (c1 & (x[i] ^ y[i]));
        end
      end
      for (int i = 0; i < 32; i++) begin
        if (i >= lo && i <= hi) begin
          s[i] = csel ? s1[i] : s0[i];
        end
      end
      csel = csel ? c1 : c0;
    end
    return {csel, s};
  endfunction

  logic        s1_valid;
  logic        s1_c32;
  logic [31:0] s1_diff_lo;
  logic [31:0] s1_a_hi;
  logic [31:0] s1_nb_hi;
  logic        s2_valid;
  logic        s1_load;
  logic        s2_load;
  logic [32:0] lo_res;
  logic [32:0] hi_res;

  // Stage 2 moves when it is empty or its result leaves; stage 1 follows.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Subtraction as a + ~b + !bin; carry out of the top is the inverted borrow.
  assign lo_res = csel_add32(a[31:0], ~b[31:0], ~bin);
  assign hi_res = csel_add32(s1_a_hi, s1_nb_hi, s1_c32);

  // Stage 1: low half result, carry into the upper half and upper operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_c32     <= 1'b0;
      s1_diff_lo <= '0;
      s1_a_hi    <= '0;
      s1_nb_hi   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_c32     <= lo_res[32];
        s1_diff_lo <= lo_res[31:0];
        s1_a_hi    <= a[63:32];
        s1_nb_hi   <= ~b[63:32];
      end
    end
  end

  // Stage 2: upper half result, final borrow (and overflow) held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef CSLA_SUB_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff <= {hi_res[31:0], s1_diff_lo};
        bout <= ~hi_res[32];
`ifdef CSLA_SUB_OVF_EN
        // b[63] is the inverse of the stored ~b[63]; a[63] is already held.
        ovf  <= (s1_a_hi[31] != ~s1_nb_hi[31]) && (hi_res[31] != s1_a_hi[31]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_csla_sub_64bit_pipe.sv
// tb/tb_csla_sub_64bit_pipe.sv - scoreboard bench for csla_sub_64bit_pipe
module tb_csla_sub_64bit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf_obs;

`ifdef CSLA_SUB_OVF_EN
  logic        ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  csla_sub_64bit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef CSLA_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          n_pops;
  int          n_push;
  logic [65:0] exp_q[$];

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result packed as {ovf, bout, diff}.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y, input logic bi);
    logic [64:0] r;
    logic        v;
    r = {1'b0, x} - {1'b0, y} - {64'd0, bi};
    v = 1'b0;
`ifdef CSLA_SUB_OVF_EN
    v = (x[63] != y[63]) && (r[63] != x[63]);
`endif
    return {v, r[64], r[63:0]};
  endfunction

  // One clock: drive inputs after the falling edge, then account for the
  // transfers that the next rising edge will perform.
  task automatic cycle(input logic iv, input logic [63:0] xa, input logic [63:0] xb,
                       input logic xbi, input logic ordy);
    logic [65:0] e;
    @(negedge clk);
    in_valid  = iv;
    a         = xa;
    b         = xb;
    bin       = xbi;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", {1'b0, out_valid, diff}, 66'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {ovf_obs, bout, diff}, e);
      end
    end
    if (in_valid && in_ready) begin
      n_push++;
      exp_q.push_back(model(xa, xb, xbi));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, 1'b0, 1'b1);
  endtask

  logic [63:0] held;
  int          p0;
  int          q0;

  initial begin
    n_checks = 0; n_errors = 0; n_pops = 0; n_push = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {65'd0, out_valid}, 66'd0);
    check("rst_diff", {2'b0, diff}, 66'd0);
    check("rst_bout_ovf", {64'd0, ovf_obs, bout}, 66'd0);
    check("rst_in_ready", {65'd0, in_ready}, 66'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic op with latency check: result appears two edges after acceptance.
    cycle(1'b1, 64'd5, 64'd3, 1'b0, 1'b1);
    check("first_accept", {65'd0, in_ready}, 66'd1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("lat_cycle1", {65'd0, out_valid}, 66'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("lat_cycle2", {65'd0, out_valid}, 66'd1);
    check("basic_diff", {2'b0, diff}, {2'b0, 64'd2});

    // Directed corner cases.
    cycle(1'b1, 64'd0, 64'd1, 1'b0, 1'b1);
    cycle(1'b1, 64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b1);
    cycle(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    cycle(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    idle(3);

    // Eight back-to-back ops: eight results in ten cycles means no gaps.
    p0 = n_pops;
    for (int i = 0; i < 8; i++) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1);
    idle(2);
    check("stream_count", 66'(n_pops - p0), 66'd8);

    // Stall from empty: two ops fill the pipe, then in_ready drops and diff holds.
    q0 = n_push;
    cycle(1'b1, 64'd100, 64'd1, 1'b0, 1'b0);
    cycle(1'b1, 64'd200, 64'd2, 1'b0, 1'b0);
    cycle(1'b1, 64'd300, 64'd3, 1'b0, 1'b0);
    check("stall_accepted", 66'(n_push - q0), 66'd2);
    check("stall_in_ready", {65'd0, in_ready}, 66'd0);
    check("stall_out_valid", {65'd0, out_valid}, 66'd1);
    held = diff;
    cycle(1'b1, 64'd400, 64'd4, 1'b0, 1'b0);
    check("stall_hold", {2'b0, diff}, {2'b0, held});
    check("stall_hold_val", {2'b0, diff}, {2'b0, 64'd99});

    // Full pipe with both transfers: stays full, nothing lost.
    cycle(1'b1, 64'd500, 64'd5, 1'b0, 1'b1);
    check("full_pass_in_ready", {65'd0, in_ready}, 66'd1);
    cycle(1'b1, 64'd600, 64'd6, 1'b1, 1'b1);
    idle(3);

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    idle(4);
    check("drained", 66'(exp_q.size()), 66'd0);

    // Reset with two ops in flight discards them.
    cycle(1'b1, 64'd7, 64'd1, 1'b0, 1'b0);
    cycle(1'b1, 64'd8, 64'd1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {65'd0, out_valid}, 66'd0);
    check("midrst_in_ready", {65'd0, in_ready}, 66'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    p0 = n_pops;
    idle(4);
    check("no_stale", 66'(n_pops - p0), 66'd0);

    // Post-reset operation still correct.
    cycle(1'b1, 64'd10, 64'd3, 1'b1, 1'b1);
    idle(3);
    check("final_drained", 66'(exp_q.size()), 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
